sar_tx_framer: RTL and testbench
================================

// Module: sar_tx_framer
// PURPOSE
// Downstream stage of the acquisition-control FSM. On start_i (that FSM's start_tx pulse) it latches
// one SAR conversion result and builds a 4-byte frame: header, data high byte, data low byte, checksum.
// It hands the bytes one at a time to the UART transmitter and returns a one-cycle eot_o pulse.
// eot_o feeds the FSM's eot input. A tick_1ms_i-based watchdog keeps a stalled UART from hanging the loop.
// PARAMETERS
// Width      8     UART byte width; frame bytes and tx_data_o are Width bits
// SarWidth   12    SAR result width; legal range 9..16, zero-padded to 16 bits
// Header     8'hA5 first byte of every frame
// TimeoutMs  5     tick_1ms_i ticks allowed per byte before abort; legal range 1..255
// PORTS
// clk_i           in   1         system clock
// rst_i           in   1         reset, asynchronous, active-high
// start_i         in   1         1-cycle pulse: latch sar_data_i and send a frame
// sar_data_i      in   SarWidth  SAR result, sampled only in the start_i cycle
// tick_1ms_i      in   1         1-cycle pulse every 1 ms, shared timebase
// tx_done_tick_i  in   1         1-cycle pulse from UART tx: current byte fully shifted out
// tx_start_o      out  1         1-cycle pulse: UART tx loads tx_data_o
// tx_data_o       out  Width     byte being transmitted; held stable from tx_start_o until tx_done_tick_i
// busy_o          out  1         high from the cycle after start_i until eot_o, inclusive
// eot_o           out  1         1-cycle pulse: frame finished or aborted
// err_o           out  1         1-cycle pulse, coincident with eot_o, only on watchdog abort
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; byte index 0; data and checksum registers 0. Reset aborts any frame silently (no eot_o).
// - States:
//   - IDLE: on start_i, latch d16 = zero-extended sar_data_i; preload checksum = Header; go to SEND.
//   - SEND: pulse tx_start_o with tx_data_o = byte[idx]; clear watchdog; go to WAIT.
//   - WAIT: on tx_done_tick_i, if idx==3 go to DONE, else idx+1 and go to SEND.
//     Otherwise each tick_1ms_i increments the watchdog; on reaching TimeoutMs go to DONE with abort flag.
//   - DONE: pulse eot_o (plus err_o if aborted); clear idx and abort flag; go to IDLE.
// - Byte order: byte0 = Header, byte1 = d16[15:8], byte2 = d16[7:0], byte3 = checksum.
// - Checksum: 8-bit sum mod 256 of bytes 0..2; carries discarded; accumulated as each byte is issued.
// - Latency: start_i at cycle t gives tx_start_o at t+2 (IDLE to SEND, then SEND).
//   tx_done_tick_i at cycle u gives the next tx_start_o at u+2; after the last byte, eot_o at u+2.
// - tx_data_o registered; changes only in the SEND cycle.
// - start_i while busy_o=1, or in the DONE cycle: ignored; the latched data is not overwritten.
// - tx_done_tick_i outside WAIT: ignored.
// - tx_done_tick_i and tick_1ms_i in the same cycle, with the watchdog at TimeoutMs-1: done wins; no abort.
// - Watchdog counts ticks, not cycles: timeout lands between TimeoutMs-1 and TimeoutMs ms after SEND.
// - Back-to-back frames: a start_i arriving in the first IDLE cycle after DONE is accepted.
// TESTING
// 1. sar_data_i=12'hABC, tx_done 20 cyc after each tx_start -> tx_data A5,0A,BC,6B in order; one eot_o; err_o=0.
// 2. sar_data_i=12'h000 -> A5,00,00,A5; then 12'hFFF -> A5,0F,FF,B3 (sum wraps mod 256).
// 3. start_i pulsed again mid-frame with 12'h123 -> ignored; first frame bytes unchanged; exactly one eot_o.
// 4. No tx_done after byte1, TimeoutMs=5, ticks every 100 cyc -> eot_o with err_o after 5th tick; busy_o drops; next start_i accepted.
// 5. rst_i asserted while waiting on byte2 -> all outputs 0 next cycle; no eot_o; new frame after release starts with A5.
// 6. tx_done_tick_i and tick_1ms_i together, watchdog at 4 -> no abort; frame completes normally.

Source files
------------

// File: rtl/sar_tx_framer.sv
// SAR result framer: latches one conversion result and sends a
// 4-byte frame (header, data hi, data lo, checksum) to a UART tx.
module sar_tx_framer #(
    parameter int              Width     = 8,
    parameter int              SarWidth  = 12,
    parameter logic [Width-1:0] Header   = 'hA5,
    parameter int              TimeoutMs = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [SarWidth-1:0] sar_data_i,
    input  logic                tick_1ms_i,
    input  logic                tx_done_tick_i,
    output logic                tx_start_o,
    output logic [Width-1:0]    tx_data_o,
    output logic                busy_o,
    output logic                eot_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      d16_q, d16_d;
    logic [Width-1:0] csum_q, csum_d;
    logic [Width-1:0] tx_data_q, tx_data_d;
    logic [7:0]       wd_q, wd_d;
    logic             abort_q, abort_d;
    logic             tx_start_q, tx_start_d;
    logic             busy_q, busy_d;
    logic             eot_q, eot_d;
    logic             err_q, err_d;

    logic [Width-1:0] byte_w;
    logic [7:0]       wd_inc;

    assign wd_inc = wd_q + 8'd1;

    // Select the frame byte addressed by the current index.
    always_comb begin
        byte_w = csum_q;
        unique case (idx_q)
            2'd0:    byte_w = Header;
            2'd1:    byte_w = Width'(d16_q[15:8]);
            2'd2:    byte_w = Width'(d16_q[7:0]);
            default: byte_w = csum_q;
        endcase
    end

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        d16_d      = d16_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        wd_d       = wd_q;
        abort_d    = abort_q;
        tx_start_d = 1'b0;
        eot_d      = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q & ~eot_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    d16_d   = 16'(sar_data_i);
                    csum_d  = Header;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_start_d = 1'b1;
                tx_data_d  = byte_w;
                if (idx_q == 2'd1 || idx_q == 2'd2) begin
                    csum_d = csum_q + byte_w;
                end
                wd_d    = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                // A finished byte takes priority over a watchdog tick.
                if (tx_done_tick_i) begin
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end
                end else if (tick_1ms_i) begin
                    wd_d = wd_inc;
                    if (wd_inc == 8'(TimeoutMs)) begin
                        abort_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: begin
                eot_d   = 1'b1;
                err_d   = abort_q;
                idx_d   = 2'd0;
                abort_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any frame in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            d16_q      <= 16'd0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            wd_q       <= 8'd0;
            abort_q    <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            eot_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            d16_q      <= d16_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            wd_q       <= wd_d;
            abort_q    <= abort_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            eot_q      <= eot_d;
            err_q      <= err_d;
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign busy_o     = busy_q;
    assign eot_o      = eot_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_sar_tx_framer.sv
// Bench for sar_tx_framer: directed frames, expected bytes and
// end-of-transfer events queued and checked by a monitor.
module tb_sar_tx_framer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [11:0] sar_data_i;
    logic        tick_1ms_i;
    logic        tx_done_tick_i;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        busy_o;
    logic        eot_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    int eot_cnt  = 0;
    logic [8:0] exp_q[$];
    logic [8:0] e;

    sar_tx_framer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .sar_data_i     (sar_data_i),
        .tick_1ms_i     (tick_1ms_i),
        .tx_done_tick_i (tx_done_tick_i),
        .tx_start_o     (tx_start_o),
        .tx_data_o      (tx_data_o),
        .busy_o         (busy_o),
        .eot_o          (eot_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard monitor: bytes are {0,data}, eot events are {1,err}.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (tx_start_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_byte got=%h exp=none", tx_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (e != {1'b0, tx_data_o}) begin
                        failures++;
                        $display("FAIL tx_byte got=%h exp=%h", {1'b0, tx_data_o}, e);
                    end
                end
            end
            if (eot_o) begin
                eot_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL eot got=err%0d exp=none", err_o);
                end else begin
                    e = exp_q.pop_front();
                    if (e != {1'b1, 7'd0, err_o}) begin
                        failures++;
                        $display("FAIL eot got=%h exp=%h", {1'b1, 7'd0, err_o}, e);
                    end
                end
            end else if (err_o) begin
                checks++;
                failures++;
                $display("FAIL err_without_eot got=1 exp=0");
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic void push_frame(input logic [7:0] b1, input logic [7:0] b2,
                                       input logic [7:0] b3);
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, b1});
        exp_q.push_back({1'b0, b2});
        exp_q.push_back({1'b0, b3});
        exp_q.push_back(9'h100);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [11:0] d, input bit chk_busy);
        sar_data_i = d;
        start_i    = 1'b1;
        cyc(1);
        start_i    = 1'b0;
        if (chk_busy) chk("busy_after_start", busy_o, 1);
    endtask

    task automatic wait_start();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx_start_o) begin
                ok = 1;
                break;
            end
            cyc(1);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL tx_start_timeout got=0 exp=1");
        end
    endtask

    task automatic wait_eot();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (eot_o) begin
                ok = 1;
                break;
            end
            cyc(1);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL eot_timeout got=0 exp=1");
        end
    endtask

    task automatic done_pulse();
        tx_done_tick_i = 1'b1;
        cyc(1);
        tx_done_tick_i = 1'b0;
    endtask

    task automatic tick_pulse();
        tick_1ms_i = 1'b1;
        cyc(1);
        tick_1ms_i = 1'b0;
    endtask

    task automatic serve_byte();
        wait_start();
        cyc(20);
        done_pulse();
    endtask

    initial begin
        int n;
        rst_i          = 1'b1;
        start_i        = 1'b0;
        sar_data_i     = 12'h0;
        tick_1ms_i     = 1'b0;
        tx_done_tick_i = 1'b0;
        cyc(3);
        chk("reset_outputs", {tx_start_o, busy_o, eot_o, err_o, tx_data_o}, 0);
        rst_i = 1'b0;
        cyc(2);

        // Frame 0xABC: checksum A5+0A+BC = 6B.
        push_frame(8'h0A, 8'hBC, 8'h6B);
        do_start(12'hABC, 1);
        repeat (4) serve_byte();
        wait_eot();
        cyc(1);
        chk("busy_after_eot", busy_o, 0);

        // Zero data, then all-ones back to back; second sum wraps.
        cyc(3);
        push_frame(8'h00, 8'h00, 8'hA5);
        do_start(12'h000, 1);
        repeat (4) serve_byte();
        wait_eot();
        push_frame(8'h0F, 8'hFF, 8'hB3);
        do_start(12'hFFF, 1);
        repeat (4) serve_byte();
        wait_eot();
        cyc(3);

        // Start during a frame is ignored.
        push_frame(8'h05, 8'hA7, 8'h51);
        do_start(12'h5A7, 1);
        serve_byte();
        wait_start();
        do_start(12'h123, 0);
        cyc(18);
        done_pulse();
        serve_byte();
        serve_byte();
        n = eot_cnt;
        wait_eot();
        cyc(60);
        chk("single_eot", eot_cnt - n, 1);
        chk("idle_after_ignored", busy_o, 0);

        // Watchdog abort while waiting on byte1.
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h04});
        exp_q.push_back(9'h101);
        do_start(12'h456, 1);
        serve_byte();
        wait_start();
        n = eot_cnt;
        for (int i = 0; i < 4; i++) begin
            cyc(99);
            tick_pulse();
        end
        cyc(10);
        chk("no_early_abort", eot_cnt - n, 0);
        chk("busy_before_abort", busy_o, 1);
        cyc(89);
        tick_pulse();
        wait_eot();
        chk("abort_err", err_o, 1);
        cyc(1);
        chk("busy_after_abort", busy_o, 0);
        cyc(2);
        push_frame(8'h0A, 8'hBC, 8'h6B);
        do_start(12'hABC, 1);
        repeat (4) serve_byte();
        wait_eot();
        cyc(3);

        // Reset while waiting on byte2: silent abort.
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h03});
        exp_q.push_back({1'b0, 8'h21});
        do_start(12'h321, 1);
        serve_byte();
        serve_byte();
        wait_start();
        cyc(3);
        n = eot_cnt;
        rst_i = 1'b1;
        cyc(1);
        chk("reset_midframe", {tx_start_o, busy_o, eot_o, err_o, tx_data_o}, 0);
        chk("queue_at_reset", exp_q.size(), 0);
        exp_q.delete();
        cyc(1);
        rst_i = 1'b0;
        cyc(20);
        chk("no_eot_on_reset", eot_cnt - n, 0);
        push_frame(8'h0A, 8'hBC, 8'h6B);
        do_start(12'hABC, 1);
        repeat (4) serve_byte();
        wait_eot();
        cyc(3);

        // Done and tick together with watchdog at 4: done wins.
        push_frame(8'h08, 8'h00, 8'hAD);
        do_start(12'h800, 1);
        serve_byte();
        wait_start();
        for (int i = 0; i < 4; i++) begin
            tick_pulse();
            cyc(1);
        end
        tick_1ms_i     = 1'b1;
        tx_done_tick_i = 1'b1;
        cyc(1);
        tick_1ms_i     = 1'b0;
        tx_done_tick_i = 1'b0;
        serve_byte();
        serve_byte();
        wait_eot();
        chk("tie_no_err", err_o, 0);
        cyc(5);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
